trigger_delay_meter: RTL and testbench
======================================

Name: trigger_delay_meter

Overview:
Measures the elapsed clk cycles between a rising edge on trigger_in and the next rising edge on echo_in, for example a trigger sent out and its delayed return.
- Presents the result on a valid/ready handshake, with a timeout flag when no echo arrives within TIMEOUT cycles.
- Sits at the receive end of the trigger path and is used to characterise and calibrate delayed-trigger chains.
- All inputs are synchronous to clk. No synchronizers are included.

Parameters:
- COUNT_WIDTH, 16, width of the counter and of delay_out.
- TIMEOUT, 50000, maximum cycles to wait for an echo. Requires 1 <= TIMEOUT <= 2^COUNT_WIDTH-1.

Ports:
- clk  in  1  clock
- reset  in  1  reset
- trigger_in  in  1  start event; level input, rising edge is the event
- echo_in  in  1  stop event; level input, rising edge is the event
- result_ready  in  1  consumer accepts the result
- delay_out  out  COUNT_WIDTH  measured delay in cycles
- delay_valid  out  1  result present, held until accepted
- timeout  out  1  result is a timeout; qualified by delay_valid
- busy  out  1  a measurement is in progress (state COUNTING)
- overrun  out  1  one-cycle pulse: trigger edge ignored because the block is not IDLE

Behaviour:
- Reset: reset is synchronous, active-high; clock is clk.
  - All outputs reset to 0. State resets to IDLE and the counter to 0.
  - Edge-detect history registers reset to 1, so an input held high through reset is not an edge.
- Edge detect: edge = in & ~prev. prev is registered every cycle in every state.
- States are IDLE, COUNTING and HOLD.
- IDLE:
  - A trigger edge sets counter <= 1, sets state COUNTING and sets busy <= 1.
  - Echo edges are ignored.
- COUNTING (checked in priority order):
  - Echo edge: delay_out <= counter, timeout <= 0, delay_valid <= 1, busy <= 0, state HOLD.
  - Else if counter == TIMEOUT: delay_out <= TIMEOUT, timeout <= 1, delay_valid <= 1, busy <= 0, state HOLD.
  - Else: counter <= counter + 1.
  - A trigger edge in this state pulses overrun and does not restart the measurement.
- Delay definition: the trigger edge is detected in cycle t and the echo edge in cycle t+N, giving delay_out = N.
  - N >= 1. An echo in the same cycle as the trigger edge is ignored.
  - delay_valid rises in cycle t+N+1.
- Echo and timeout in the same cycle: the echo wins, giving delay_out = TIMEOUT with timeout = 0.
- HOLD:
  - delay_valid, delay_out and timeout are held stable.
  - On delay_valid & result_ready: delay_valid <= 0, timeout <= 0, state IDLE. delay_out keeps its last value.
  - If result_ready is already high on entry, delay_valid lasts exactly 1 cycle.
  - A trigger edge in any HOLD cycle, including the handoff cycle, pulses overrun and is dropped.
- Counter never wraps: the TIMEOUT bound guarantees this.
- Reset mid-operation: the block returns to reset values the next cycle. Any pending result is discarded.

Decomposition:
- Package trigger_meter_pkg:
  - state enum IDLE/COUNTING/HOLD.
  - localparam widths for the state encoding.
- Sub-module rise_detect:
  - Ports: clk, reset, in, edge.
  - Has a parameter for the reset value of prev (1 here).
  - Instantiated twice.

Test Plan:
COUNT_WIDTH=8, TIMEOUT=10 unless noted.
1. Basic: after reset, raise trigger_in, then raise echo_in 3 cycles after the trigger edge is detected; result_ready=0 -> delay_out=3, timeout=0, delay_valid high and stable until result_ready is raised, low one cycle later. busy is high for exactly 3 cycles.
2. Timeout: trigger edge, echo never rises -> delay_valid rises with delay_out=10, timeout=1. An echo arriving later in HOLD does not change delay_out.
3. Boundary: echo edge exactly 10 cycles after the trigger -> delay_out=10, timeout=0. Echo 1 cycle after the trigger -> delay_out=1. Echo in the same cycle as the trigger -> ignored, result is a timeout.
4. Ignored events: echo edges while IDLE -> no activity. A second trigger edge during COUNTING and another during HOLD -> overrun pulses once each, first measurement unaffected.
5. Back-to-back: result_ready tied high, trigger/echo pairs with delays 2 and 5 with a one-cycle IDLE gap -> two one-cycle delay_valid pulses carrying 2 then 5, no overrun.
6. Reset: assert reset at counter=4 in COUNTING -> next cycle all outputs 0 and state IDLE. trigger_in held high through reset -> no measurement starts. A later clean trigger/echo pair measures correctly.

Source files
------------

// File: rtl/trigger_delay_meter_pkg.sv
// Shared types for the trigger-to-echo delay meter.
package trigger_meter_pkg;
  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE     = 2'd0,
    COUNTING = 2'd1,
    HOLD     = 2'd2
  } state_t;
endpackage

// File: rtl/trigger_delay_meter_rise_detect.sv
// Rising-edge detector; prev resets to PREV_RST so a level held through reset is not an edge.
module rise_detect
  import trigger_meter_pkg::*;
#(
  parameter logic PREV_RST = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_in,
  output logic o_edge
);
  logic r_prev;

  always_ff @(posedge clk) begin
    if (reset) r_prev <= PREV_RST;
    else       r_prev <= i_in;
  end

  assign o_edge = i_in & ~r_prev;
endmodule

// File: rtl/trigger_delay_meter.sv
// Counts clk cycles from a trigger rising edge to the next echo rising edge,
// with a timeout bound and a valid/ready result hold.
module trigger_delay_meter
  import trigger_meter_pkg::*;
#(
  parameter int COUNT_WIDTH = 16,
  parameter int TIMEOUT     = 50000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   trigger_in,
  input  logic                   echo_in,
  input  logic                   result_ready,
  output logic [COUNT_WIDTH-1:0] delay_out,
  output logic                   delay_valid,
  output logic                   timeout,
  output logic                   busy,
  output logic                   overrun
);
  localparam logic [COUNT_WIDTH-1:0] TMO_VAL = COUNT_WIDTH'(TIMEOUT);
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

  logic w_trig_edge, w_echo_edge;

  rise_detect #(.PREV_RST(1'b1)) u_trig_rd (
    .clk(clk), .reset(reset), .i_in(trigger_in), .o_edge(w_trig_edge)
  );
  rise_detect #(.PREV_RST(1'b1)) u_echo_rd (
    .clk(clk), .reset(reset), .i_in(echo_in), .o_edge(w_echo_edge)
  );

  state_t                 r_state, w_state_nxt;
  logic [COUNT_WIDTH-1:0] r_cnt, w_cnt_nxt;
  logic [COUNT_WIDTH-1:0] r_delay, w_delay_nxt;
  logic                   r_valid, w_valid_nxt;
  logic                   r_tmo, w_tmo_nxt;
  logic                   r_busy, w_busy_nxt;
  logic                   r_ovr, w_ovr_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_delay <= '0;
      r_valid <= 1'b0;
      r_tmo   <= 1'b0;
      r_busy  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_delay <= w_delay_nxt;
      r_valid <= w_valid_nxt;
      r_tmo   <= w_tmo_nxt;
      r_busy  <= w_busy_nxt;
      r_ovr   <= w_ovr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_delay_nxt = r_delay;
    w_valid_nxt = r_valid;
    w_tmo_nxt   = r_tmo;
    w_busy_nxt  = r_busy;
    // A trigger edge outside IDLE is dropped, including the HOLD handoff cycle.
    w_ovr_nxt   = w_trig_edge && (r_state != IDLE);
    case (r_state)
      IDLE: begin
        if (w_trig_edge) begin
          w_cnt_nxt   = CNT_ONE;
          w_busy_nxt  = 1'b1;
          w_state_nxt = COUNTING;
        end
      end
      COUNTING: begin
        // Echo is checked first so an echo on the last count is a real measurement.
        if (w_echo_edge) begin
          w_delay_nxt = r_cnt;
          w_tmo_nxt   = 1'b0;
          w_valid_nxt = 1'b1;
          w_busy_nxt  = 1'b0;
          w_state_nxt = HOLD;
        end else if (r_cnt == TMO_VAL) begin
          w_delay_nxt = TMO_VAL;
          w_tmo_nxt   = 1'b1;
          w_valid_nxt = 1'b1;
          w_busy_nxt  = 1'b0;
          w_state_nxt = HOLD;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      HOLD: begin
        if (r_valid && result_ready) begin
          w_valid_nxt = 1'b0;
          w_tmo_nxt   = 1'b0;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign delay_out   = r_delay;
  assign delay_valid = r_valid;
  assign timeout     = r_tmo;
  assign busy        = r_busy;
  assign overrun     = r_ovr;
endmodule

// File: tb/tb_trigger_delay_meter.sv
// Bench for trigger_delay_meter: directed and random measurements against an arithmetic expectation.
module tb_trigger_delay_meter;
  localparam int CW = 8;
  localparam int TO = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          trigger_in = 1'b0;
  logic          echo_in = 1'b0;
  logic          result_ready = 1'b0;
  logic [CW-1:0] delay_out;
  logic          delay_valid, timeout, busy, overrun;

  int n_vec = 0;
  int n_bad = 0;
  int last_delay = 0;

  trigger_delay_meter #(.COUNT_WIDTH(CW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .trigger_in(trigger_in), .echo_in(echo_in),
    .result_ready(result_ready), .delay_out(delay_out), .delay_valid(delay_valid),
    .timeout(timeout), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input logic trg, input logic ech, input logic rdy);
    trigger_in   = trg;
    echo_in      = ech;
    result_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".busy"},    busy,        0);
    chk({tag, ".valid"},   delay_valid, 0);
    chk({tag, ".timeout"}, timeout,     0);
    chk({tag, ".overrun"}, overrun,     0);
    chk({tag, ".delay"},   delay_out,   last_delay);
  endtask

  // One measurement: trigger rises at step 0, echo rises at step echo_at (level, -1 = never),
  // optional trigger re-pulse (low at retrig_at, edge at retrig_at+1), ready rises at ready_at.
  task automatic meas(input string tag, input int echo_at, input int retrig_at, input int ready_at);
    bit hit;
    int nend, rs, exp_d, rt;
    hit   = (echo_at >= 1) && (echo_at <= TO);
    nend  = hit ? echo_at : TO;
    exp_d = nend;
    rs    = (ready_at > nend + 1) ? ready_at : nend + 1;
    rt    = (retrig_at >= 1 && retrig_at < rs) ? retrig_at : -1;
    step(1'b0, 1'b0, ready_at <= 0);
    chk_idle({tag, ".pre"});
    for (int s = 0; s <= rs; s++) begin
      step(!(rt >= 1 && s == rt), (echo_at >= 0) && (s >= echo_at), s >= ready_at);
      chk({tag, ".busy"},    busy,        s < nend);
      chk({tag, ".valid"},   delay_valid, (s >= nend) && (s < rs));
      chk({tag, ".timeout"}, timeout,     (s >= nend) && (s < rs) && !hit);
      chk({tag, ".overrun"}, overrun,     (rt >= 1) && (s == rt + 1));
      chk({tag, ".delay"},   delay_out,   (s >= nend) ? exp_d : last_delay);
    end
    last_delay = exp_d;
  endtask

  initial begin
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk_idle("reset");
    reset = 1'b0;

    meas("basic", 3, -1, 8);
    meas("tmo", -1, -1, 14);
    meas("tmo_late_echo", 13, -1, 16);
    meas("echo_at_tmo", 10, -1, 12);
    meas("echo_1", 1, -1, 3);
    meas("echo_same", 0, -1, 13);

    for (int i = 0; i < 6; i++) begin
      step(1'b0, i[0], 1'b0);
      chk_idle("idle_echo");
    end
    meas("ovr_count", 4, 2, 8);
    meas("ovr_hold", 3, 5, 8);

    meas("b2b_a", 2, -1, 0);
    meas("b2b_b", 5, -1, 0);

    // Reset mid-count with trigger held high through and after reset.
    step(1'b0, 1'b0, 1'b0);
    for (int s = 0; s < 4; s++) step(1'b1, 1'b0, 1'b0);
    chk("rst.busy_before", busy, 1);
    reset = 1'b1;
    step(1'b1, 1'b0, 1'b0);
    last_delay = 0;
    chk_idle("rst.during");
    reset = 1'b0;
    for (int s = 0; s < 4; s++) begin
      step(1'b1, s >= 2, 1'b0);
      chk_idle("rst.after");
    end
    meas("rst.clean", 6, -1, 9);

    for (int i = 0; i < 20; i++) begin
      int e, r, t;
      e = $urandom_range(0, TO + 3);
      if (e == TO + 3) e = -1;
      r = $urandom_range(0, TO + 6);
      t = $urandom_range(0, 2 * TO);
      meas("rand", e, t, r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
